// File: rtl/clock.sv
// Fixed-ratio clock divider: clkout toggles every STEP rising edges of clk,
// giving a 50 % duty square wave at f_clk / (2*STEP).
module clock #(
  parameter int STEP = 25000000,
  parameter int LEN  = 25
) (
  input  logic clk,
  input  logic rst,
  output logic clkout
);

  // Refuse to build a divider whose counter cannot reach STEP-1.
  generate
    if (STEP < 2 || (2 ** LEN) < STEP) begin : g_bad_params
      $error("clock: illegal STEP/LEN combination");
    end
  endgenerate

  localparam logic [LEN-1:0] CNT_LAST = LEN'(STEP - 1);

  logic [LEN-1:0] r_cnt;
  logic           r_clkout;
  logic           w_wrap;

  assign w_wrap = (r_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt    <= '0;
      r_clkout <= 1'b0;
    end else if (w_wrap) begin
      r_cnt    <= '0;
      r_clkout <= ~r_clkout;
    end else begin
      r_cnt    <= r_cnt + 1'b1;
    end
  end

  assign clkout = r_clkout;

endmodule

// File: tb/tb_clock.sv
// Bench for the clock divider: three instances on a shared clock and reset,
// toggle-edge scoreboard plus snapshots around asynchronous reset assertion.
module tb_clock;

  localparam int S0 = 5;
  localparam int S1 = 25;
  localparam int S2 = 6250;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic co0, co1, co2;

  clock #(.STEP(S0), .LEN(3))  u0 (.clk(clk), .rst(rst), .clkout(co0));
  clock #(.STEP(S1), .LEN(5))  u1 (.clk(clk), .rst(rst), .clkout(co1));
  clock #(.STEP(S2), .LEN(13)) u2 (.clk(clk), .rst(rst), .clkout(co2));

  always #10 clk = ~clk;

  // Entry: {instance[1:0], edge index since release[28:0], level after toggle}
  logic [31:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int edge_cnt = 0;
  int max_cnt[3] = '{0, 0, 0};

  function automatic int step_of(int i);
    case (i)
      0:       return S0;
      1:       return S1;
      default: return S2;
    endcase
  endfunction

  function automatic int cnt_of(int i);
    case (i)
      0:       return int'(u0.r_cnt);
      1:       return int'(u1.r_cnt);
      default: return int'(u2.r_cnt);
    endcase
  endfunction

  function automatic logic out_of(int i);
    case (i)
      0:       return co0;
      1:       return co1;
      default: return co2;
    endcase
  endfunction

  function automatic logic [31:0] pack_word(int i, int e, logic lvl);
    logic [1:0]  ii;
    logic [28:0] ee;
    ii = 2'(i);
    ee = 29'(e);
    return {ii, ee, lvl};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every observed clkout change must match the head of the queue.
  initial begin
    logic prev[3];
    logic r;
    logic cur;
    logic [31:0] e;
    prev = '{1'b0, 1'b0, 1'b0};
    forever begin
      @(posedge clk);
      r = rst;
      #1;
      if (!r) begin
        edge_cnt = 0;
        for (int i = 0; i < 3; i++) prev[i] = out_of(i);
      end else begin
        edge_cnt++;
        for (int i = 0; i < 3; i++) begin
          if (cnt_of(i) > max_cnt[i]) max_cnt[i] = cnt_of(i);
          cur = out_of(i);
          if (cur !== prev[i]) begin
            if (exp_q.size() == 0) begin
              check($sformatf("unexpected_toggle_u%0d", i), pack_word(i, edge_cnt, cur), 32'hFFFF_FFFF);
            end else begin
              e = exp_q.pop_front();
              check($sformatf("toggle_u%0d", i), pack_word(i, edge_cnt, cur), e);
            end
            prev[i] = cur;
          end
        end
      end
    end
  end

  // Release reset, run n edges, snapshot, then assert reset between edges.
  task automatic run_phase(int n);
    int hold;
    for (int e = 1; e <= n; e++) begin
      for (int i = 0; i < 3; i++) begin
        if (e % step_of(i) == 0) exp_q.push_back(pack_word(i, e, logic'((e / step_of(i)) % 2)));
      end
    end
    @(negedge clk);
    #($urandom_range(1, 8));
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #($urandom_range(2, 17));
    for (int i = 0; i < 3; i++) begin
      check($sformatf("cnt_u%0d_after_%0d", i, n), 32'(cnt_of(i)), 32'(n % step_of(i)));
      check($sformatf("out_u%0d_after_%0d", i, n), 32'(out_of(i)), 32'((n / step_of(i)) % 2));
    end
    check("pending_toggles", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("async_clr_cnt_u%0d", i), 32'(cnt_of(i)), 32'd0);
      check($sformatf("async_clr_out_u%0d", i), 32'(out_of(i)), 32'd0);
    end
    hold = $urandom_range(1, 4);
    repeat (hold) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) check($sformatf("held_out_u%0d", i), 32'(out_of(i)), 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset_cnt_u%0d", i), 32'(cnt_of(i)), 32'd0);
      check($sformatf("reset_out_u%0d", i), 32'(out_of(i)), 32'd0);
    end
    run_phase(8);
    run_phase(S0);
    run_phase(S0 - 1);
    for (int k = 0; k < 5; k++) run_phase($urandom_range(1, 300));
    run_phase(2 * S2 + 500);
    for (int i = 0; i < 3; i++) check($sformatf("max_cnt_u%0d", i), 32'(max_cnt[i]), 32'(step_of(i) - 1));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/clock.md
CLOCK -- requirements
Module: clock

Interface
REQ-001 The block SHALL have parameter STEP, default 25000000, giving input-clock cycles per output half-period; legal range STEP >= 2.
REQ-002 The block SHALL have parameter LEN, default 25, giving counter width; LEN SHALL equal $clog2(STEP), so the counter holds 0..STEP-1.
REQ-003 The block SHALL have port clk, input, 1 bit: sole clock, rising-edge active.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port clkout, output, 1 bit: divided clock, driven directly from a flop.

Function
REQ-006 The block SHALL contain one LEN-bit up-counter cnt and one output flop clkout, both clocked on the rising edge of clk.
REQ-007 On each rising clk edge with rst high and cnt < STEP-1, cnt SHALL increment by 1 and clkout SHALL hold.
REQ-008 On each rising clk edge with rst high and cnt == STEP-1, cnt SHALL return to 0 and clkout SHALL invert in the same edge.
REQ-009 clkout SHALL therefore be high for exactly STEP clk cycles and low for exactly STEP clk cycles, giving f_clkout = f_clk / (2*STEP) at 50 % duty.
REQ-010 The counter SHALL never hold a value above STEP-1; no other wrap, overflow or saturation path SHALL exist.
REQ-011 The first clkout rising edge after reset release SHALL occur on the STEP-th rising clk edge sampled with rst high.
REQ-012 The block SHALL have no combinational path from clk or rst to clkout other than through the output flop and the asynchronous clear.
REQ-013 Elaboration SHALL fail when STEP < 2 or when 2**LEN < STEP.

Reset
REQ-014 While rst is low, cnt SHALL be 0 and clkout SHALL be 0, independent of clk.
REQ-015 Assertion of rst SHALL clear cnt and clkout immediately, including mid-count and mid-high-phase, with no wait for a clk edge.
REQ-016 Release of rst SHALL take effect on the first rising clk edge at which rst is sampled high; that edge SHALL count as increment 1.

Verification
REQ-017 clk 50 MHz (20 ns period), STEP=5, LEN=3, rst low for 50 cycles then high -> clkout 0 during reset, first rise on the 5th edge after release, period 200 ns (5 MHz), 100 ns high / 100 ns low.
REQ-018 Same clk, STEP=25, LEN=5 -> clkout period 1 us (1 MHz), high 25 cycles, low 25 cycles.
REQ-019 Same clk, STEP=6250, LEN=13 -> clkout period 250 us (4 kHz), 50 % duty, cnt maximum observed 6249.
REQ-020 Default parameters, 50 MHz clk -> clkout period 1 s; a shortened run SHALL show cnt reaching 24999999 and then wrapping to 0 with a clkout toggle.
REQ-021 STEP=5, rst driven low asynchronously between clk edges while clkout=1 and cnt=3 -> clkout and cnt 0 immediately; after release the full 5-cycle sequence restarts.
REQ-022 Three instances (STEP 5, 25, 6250) on a shared clk and rst -> all outputs 0 in reset and rise together on release edge 5 only for STEP=5; all later edges align to multiples of each STEP.
